// File: rtl/alu_op_sequencer.sv
// Sequences single ALU commands: reads two operands from a small register file,
// waits out the ALU pipeline, then writes the result back and pulses done.
module alu_op_sequencer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned NUM_REGS    = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [4:0]  cmd_opcode_i,
  input  logic [2:0]  cmd_src_a_i,
  input  logic [2:0]  cmd_src_b_i,
  input  logic [2:0]  cmd_dst_i,
  input  logic        load_valid_i,
  input  logic [2:0]  load_addr_i,
  input  logic [31:0] load_data_i,
  output logic [4:0]  alu_opcode_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i,
  output logic        done_o,
  output logic [31:0] done_data_o,
  input  logic [2:0]  rd_addr_i,
  output logic [31:0] rd_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  dst_q, dst_d;
  logic        done_q, done_d;
  logic [31:0] done_data_q, done_data_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] rf_view_s [8];

  // Full 3-bit address view of the file; indices beyond NUM_REGS read as zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_view
    if (gi < NUM_REGS) begin : g_hit
      assign rf_view_s[gi] = regs_q[gi];
    end else begin : g_miss
      assign rf_view_s[gi] = 32'd0;
    end
  end

  // Next-state, operand capture and register-file update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    dst_d       = dst_q;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          // Operands come from regs_q, so a same-edge load is not visible here.
          opcode_d = cmd_opcode_i;
          a_d      = rf_view_s[cmd_src_a_i];
          b_d      = rf_view_s[cmd_src_b_i];
          dst_d    = cmd_dst_i;
          cnt_d    = LAT_INIT;
          state_d  = WAIT;
        end else begin
          state_d  = IDLE;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
          if (load_valid_i && (load_addr_i == 3'(i))) begin
            regs_d[i] = load_data_i;
          end else begin
            regs_d[i] = regs_q[i];
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = WRITE;
        end else begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (dst_q == 3'(i)) begin
            regs_d[i] = alu_result_i;
          end else begin
            regs_d[i] = regs_q[i];
          end
        end
        done_d      = 1'b1;
        done_data_d = alu_result_i;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      opcode_q    <= 5'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      dst_q       <= 3'd0;
      done_q      <= 1'b0;
      done_data_q <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dst_q       <= dst_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign cmd_ready_o  = (state_q == IDLE) && !reset_i;
  assign alu_opcode_o = opcode_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign done_o       = done_q;
  assign done_data_o  = done_data_q;
  assign rd_data_o    = rf_view_s[rd_addr_i];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: a latency-1 instance driven from a vector table, plus
// hand sequences for reset-in-flight and a latency-3 instance.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // latency-1 instance signals
  logic        cv, lv, rdy, done;
  logic [4:0]  op, aop;
  logic [2:0]  sa, sb, dst, la, ra;
  logic [31:0] ld, aa, ab, ares, ddata, rdata;
  // latency-3 instance signals
  logic        cv3, lv3, rdy3, done3;
  logic [4:0]  aop3;
  logic [2:0]  sa3, sb3, dst3, la3, ra3;
  logic [31:0] ld3, aa3, ab3, ares3, ddata3, rdata3;

  int n_checks = 0;
  int n_err    = 0;

  alu_op_sequencer #(.ALU_LATENCY(1), .NUM_REGS(8)) u_dut1 (
    .clock_i(clk), .reset_i(reset),
    .cmd_valid_i(cv), .cmd_ready_o(rdy), .cmd_opcode_i(op),
    .cmd_src_a_i(sa), .cmd_src_b_i(sb), .cmd_dst_i(dst),
    .load_valid_i(lv), .load_addr_i(la), .load_data_i(ld),
    .alu_opcode_o(aop), .alu_a_o(aa), .alu_b_o(ab), .alu_result_i(ares),
    .done_o(done), .done_data_o(ddata), .rd_addr_i(ra), .rd_data_o(rdata)
  );

  alu_op_sequencer #(.ALU_LATENCY(3), .NUM_REGS(8)) u_dut3 (
    .clock_i(clk), .reset_i(reset),
    .cmd_valid_i(cv3), .cmd_ready_o(rdy3), .cmd_opcode_i(5'd0),
    .cmd_src_a_i(sa3), .cmd_src_b_i(sb3), .cmd_dst_i(dst3),
    .load_valid_i(lv3), .load_addr_i(la3), .load_data_i(ld3),
    .alu_opcode_o(aop3), .alu_a_o(aa3), .alu_b_o(ab3), .alu_result_i(ares3),
    .done_o(done3), .done_data_o(ddata3), .rd_addr_i(ra3), .rd_data_o(rdata3)
  );

  // Behavioural registered ALU: opcode 1 is XOR, anything else is ADD.
  always_ff @(posedge clk) begin
    ares  <= (aop == 5'd1) ? (aa ^ ab) : (aa + ab);
    ares3 <= aa3 + ab3;
  end

  typedef struct {
    logic        lv;
    logic [2:0]  la;
    logic [31:0] ld;
    logic        cv;
    logic [4:0]  op;
    logic [2:0]  sa, sb, dst, ra;
    logic        e_rdy, e_done;
    logic [31:0] e_dd, e_rd, e_a, e_b;
  } vec_t;

  localparam logic [31:0] R1   = 32'h44e96cb8;
  localparam logic [31:0] R2   = 32'h79adc30e;
  localparam logic [31:0] SUM1 = 32'hbe972fc6;
  localparam logic [31:0] SUM2 = 32'hbe972fc6 + 32'h44e96cb8;
  localparam logic [31:0] XR   = 32'h44e96cb8 ^ 32'h79adc30e;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cv = 1'b0; lv = 1'b0; op = 5'd0; sa = 3'd0; sb = 3'd0; dst = 3'd0;
    la = 3'd0; ld = 32'd0; ra = 3'd0;
    cv3 = 1'b0; lv3 = 1'b0; sa3 = 3'd0; sb3 = 3'd0; dst3 = 3'd0;
    la3 = 3'd0; ld3 = 32'd0; ra3 = 3'd0;
  endtask

  initial begin
    //           lv    la    ld            cv    op    sa    sb    dst   ra    rdy   done  dd    rd            a     b
    vecs[0]  = '{1'b1, 3'd1, R1,           1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 32'd0, R1,          32'd0, 32'd0};
    vecs[1]  = '{1'b1, 3'd2, R2,           1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 32'd0, R2,          32'd0, 32'd0};
    vecs[2]  = '{1'b0, 3'd0, 32'd0,        1'b1, 5'd0, 3'd1, 3'd2, 3'd3, 3'd3, 1'b0, 1'b0, 32'd0, 32'd0,       R1,    R2};
    vecs[3]  = '{1'b1, 3'd1, 32'hffffffff, 1'b1, 5'd0, 3'd3, 3'd1, 3'd4, 3'd1, 1'b0, 1'b0, 32'd0, R1,          R1,    R2};
    vecs[4]  = '{1'b0, 3'd0, 32'd0,        1'b1, 5'd0, 3'd3, 3'd1, 3'd4, 3'd3, 1'b1, 1'b1, SUM1,  SUM1,        R1,    R2};
    vecs[5]  = '{1'b0, 3'd0, 32'd0,        1'b1, 5'd0, 3'd3, 3'd1, 3'd4, 3'd4, 1'b0, 1'b0, SUM1,  32'd0,       SUM1,  R1};
    vecs[6]  = '{1'b0, 3'd0, 32'd0,        1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, SUM1,  32'd0,       SUM1,  R1};
    vecs[7]  = '{1'b0, 3'd0, 32'd0,        1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, SUM2,  SUM2,        SUM1,  R1};
    vecs[8]  = '{1'b1, 3'd2, 32'd0,        1'b1, 5'd1, 3'd1, 3'd2, 3'd5, 3'd2, 1'b0, 1'b0, SUM2,  32'd0,       R1,    R2};
    vecs[9]  = '{1'b0, 3'd0, 32'd0,        1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, SUM2,  32'd0,       R1,    R2};
    vecs[10] = '{1'b0, 3'd0, 32'd0,        1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, XR,    XR,          R1,    R2};
    vecs[11] = '{1'b0, 3'd0, 32'd0,        1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, XR,    R1,          R1,    R2};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", {31'd0, rdy}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_opcode", {27'd0, aop}, 32'd0);
    check("reset_alu_a", aa, 32'd0);
    check("reset_alu_b", ab, 32'd0);
    check("reset_done_data", ddata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra = 3'(i);
      #1;
      check($sformatf("reset_rd%0d", i), rdata, 32'd0);
    end

    // Table: loads, add, dependent back-to-back, load while busy, same-edge load.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      lv = vecs[v].lv; la = vecs[v].la; ld = vecs[v].ld;
      cv = vecs[v].cv; op = vecs[v].op; sa = vecs[v].sa; sb = vecs[v].sb;
      dst = vecs[v].dst; ra = vecs[v].ra;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready", v), {31'd0, rdy}, {31'd0, vecs[v].e_rdy});
      check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].e_done});
      check($sformatf("v%0d_done_data", v), ddata, vecs[v].e_dd);
      check($sformatf("v%0d_rd", v), rdata, vecs[v].e_rd);
      check($sformatf("v%0d_alu_a", v), aa, vecs[v].e_a);
      check($sformatf("v%0d_alu_b", v), ab, vecs[v].e_b);
    end

    // Reset pulsed while the command sits in WAIT.
    @(negedge clk);
    lv = 1'b0; cv = 1'b1; op = 5'd0; sa = 3'd1; sb = 3'd1; dst = 3'd6;
    @(posedge clk);
    #1;
    check("mid_accept_ready", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    cv = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_ready_in_reset", {31'd0, rdy}, 32'd0);
    check("mid_done_in_reset", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_ready_after", {31'd0, rdy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("mid_no_done%0d", k), {31'd0, done}, 32'd0);
    end
    check("mid_alu_a", aa, 32'd0);
    check("mid_alu_b", ab, 32'd0);
    check("mid_done_data", ddata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra = 3'(i);
      #1;
      check($sformatf("mid_rd%0d", i), rdata, 32'd0);
    end

    // Latency-3 instance: ready low 4 cycles, done in the cycle after E0+4.
    @(negedge clk);
    lv3 = 1'b1; la3 = 3'd1; ld3 = 32'hffffffff;
    @(negedge clk);
    la3 = 3'd2; ld3 = 32'd2;
    @(negedge clk);
    lv3 = 1'b0; cv3 = 1'b1; sa3 = 3'd1; sb3 = 3'd2; dst3 = 3'd7; ra3 = 3'd7;
    @(posedge clk);
    #1;
    check("l3_ready_e0", {31'd0, rdy3}, 32'd0);
    check("l3_done_e0", {31'd0, done3}, 32'd0);
    @(negedge clk);
    cv3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("l3_ready_e%0d", k), {31'd0, rdy3}, (k >= 4) ? 32'd1 : 32'd0);
      check($sformatf("l3_done_e%0d", k), {31'd0, done3}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) begin
        check("l3_done_data", ddata3, 32'd1);
      end
    end
    check("l3_rd7", rdata3, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
